// File: rtl/arc_control_unit.sv
// arc_control_unit
// ----------------
// Microsequencer for the ARC-subset uDataPath. It fetches an instruction
// over a req/ack memory port, decodes the IR fields that the datapath hands
// back, and then steps through one state per datapath cycle. In each state
// it drives the register-write select, the bus-A/B source selects, the ALU
// operation and the memory request lines.
//
// Ports
//   arc_control_unit_CLOCK_50           system clock
//   arc_control_unit_Reset_InLow        synchronous reset, active-low
//   arc_control_unit_RegIR_*            decoded IR fields from the datapath
//   arc_control_unit_*_InLow (flags)    PSR N/Z/V/C, active-low
//   arc_control_unit_MemAck_InHigh      memory completes the access this cycle
//   arc_control_unit_Step_InHigh        single-step request (optional build only)
//   arc_control_unit_DecoderSelectionWrite_Out  destination register, 63 = none
//   arc_control_unit_MUXSelectionBUSA_Out       bus-A source
//   arc_control_unit_MUXSelectionBUSB_Out       bus-B source
//   arc_control_unit_ALUSelection_Out           ALU operation
//   arc_control_unit_MemRead_OutHigh / MemWrite_OutHigh  held until ack
//   arc_control_unit_Error_OutHigh      illegal instruction seen, sticky
//   arc_control_unit_State_Out          current state, for debug
//
// Build option
//   ARC_CU_SINGLESTEP_EN  adds the Step input and a HALT state that the
//                         unit waits in before each new FETCH.

module arc_control_unit #(
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_MUX_SELECTION     = 6,
    parameter int DATAWIDTH_ALU_SELECTION     = 4
) (
    input  logic                                   arc_control_unit_CLOCK_50,
    input  logic                                   arc_control_unit_Reset_InLow,
    input  logic [1:0]                             arc_control_unit_RegIR_OP,
    input  logic [4:0]                             arc_control_unit_RegIR_RD,
    input  logic [2:0]                             arc_control_unit_RegIR_OP2,
    input  logic [5:0]                             arc_control_unit_RegIR_OP3,
    input  logic [4:0]                             arc_control_unit_RegIR_RS1,
    input  logic                                   arc_control_unit_RegIR_BIT13,
    input  logic [4:0]                             arc_control_unit_RegIR_RS2,
    input  logic                                   arc_control_unit_Negative_InLow,
    input  logic                                   arc_control_unit_Zero_InLow,
    input  logic                                   arc_control_unit_Overflow_InLow,
    input  logic                                   arc_control_unit_Carry_InLow,
    input  logic                                   arc_control_unit_MemAck_InHigh,
`ifdef ARC_CU_SINGLESTEP_EN
    input  logic                                   arc_control_unit_Step_InHigh,
`endif
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] arc_control_unit_DecoderSelectionWrite_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     arc_control_unit_MUXSelectionBUSA_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     arc_control_unit_MUXSelectionBUSB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     arc_control_unit_ALUSelection_Out,
    output logic                                   arc_control_unit_MemRead_OutHigh,
    output logic                                   arc_control_unit_MemWrite_OutHigh,
    output logic                                   arc_control_unit_Error_OutHigh,
    output logic [4:0]                             arc_control_unit_State_Out
);

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_ARITH_IMM = 5'd3,
        S_ARITH    = 5'd4,
        S_ADDR_IMM = 5'd5,
        S_LD_A     = 5'd6,
        S_ST_A     = 5'd7,
        S_LD_M     = 5'd8,
        S_ST_M     = 5'd9,
        S_SETHI    = 5'd10,
        S_BR_T     = 5'd11,
        S_BR_ADD   = 5'd12,
        S_INC_PC   = 5'd13,
        S_ILLEGAL  = 5'd14,
        S_HALT     = 5'd15
    } state_t;

    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEST_NONE  = DATAWIDTH_DECODER_SELECTION'(63);
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEST_PC    = DATAWIDTH_DECODER_SELECTION'(32);
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEST_IR    = DATAWIDTH_DECODER_SELECTION'(33);
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEST_TEMP0 = DATAWIDTH_DECODER_SELECTION'(34);
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] DEST_TEMP1 = DATAWIDTH_DECODER_SELECTION'(35);

    localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_ZERO  = DATAWIDTH_MUX_SELECTION'(0);
    localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_PC    = DATAWIDTH_MUX_SELECTION'(32);
    localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_IR    = DATAWIDTH_MUX_SELECTION'(33);
    localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_TEMP0 = DATAWIDTH_MUX_SELECTION'(34);
    localparam logic [DATAWIDTH_MUX_SELECTION-1:0] MUX_TEMP1 = DATAWIDTH_MUX_SELECTION'(35);

    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ANDCC    = DATAWIDTH_ALU_SELECTION'(0);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ORCC     = DATAWIDTH_ALU_SELECTION'(1);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ORNCC    = DATAWIDTH_ALU_SELECTION'(2);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ADDCC    = DATAWIDTH_ALU_SELECTION'(3);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ADD      = DATAWIDTH_ALU_SELECTION'(8);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_LSHIFT2  = DATAWIDTH_ALU_SELECTION'(9);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_LSHIFT10 = DATAWIDTH_ALU_SELECTION'(10);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_SEXT13   = DATAWIDTH_ALU_SELECTION'(12);
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_INCPC    = DATAWIDTH_ALU_SELECTION'(14);

    localparam logic [5:0] OP3_LD = 6'b000000;
    localparam logic [5:0] OP3_ST = 6'b000100;

    state_t                               state_q;
    state_t                               state_d;
    state_t                               dispatch_state;
    logic                                 flag_n;
    logic                                 flag_z;
    logic                                 flag_v;
    logic                                 flag_c;
    logic                                 branch_taken;
    logic                                 branch_cond_legal;
    logic                                 arith_legal;
    logic [DATAWIDTH_ALU_SELECTION-1:0]   arith_alu;
    logic [DATAWIDTH_MUX_SELECTION-1:0]   operand_b_sel;

    assign flag_n = ~arc_control_unit_Negative_InLow;
    assign flag_z = ~arc_control_unit_Zero_InLow;
    assign flag_v = ~arc_control_unit_Overflow_InLow;
    assign flag_c = ~arc_control_unit_Carry_InLow;

    // With the immediate form, the sign-extended simm13 has already been
    // parked in TEMP0 by the pre-state, so bus B takes TEMP0 instead of RS2.
    assign operand_b_sel = arc_control_unit_RegIR_BIT13 ? MUX_TEMP0
                                                        : DATAWIDTH_MUX_SELECTION'(arc_control_unit_RegIR_RS2);

    // Branch condition evaluation. Only the five supported condition codes
    // are legal; anything else is treated as an illegal instruction.
    always_comb begin
        branch_taken      = 1'b0;
        branch_cond_legal = 1'b1;
        case (arc_control_unit_RegIR_RD[3:0])
            4'b1000: branch_taken = 1'b1;
            4'b0001: branch_taken = flag_z;
            4'b0101: branch_taken = flag_c;
            4'b0110: branch_taken = flag_n;
            4'b0111: branch_taken = flag_v;
            default: branch_cond_legal = 1'b0;
        endcase
    end

    // Map the arithmetic OP3 field onto the ALU operation code and flag
    // whether it is one of the four supported arithmetic/logic ops.
    always_comb begin
        arith_alu   = ALU_ADDCC;
        arith_legal = 1'b1;
        case (arc_control_unit_RegIR_OP3)
            6'b010000: arith_alu = ALU_ADDCC;
            6'b010001: arith_alu = ALU_ANDCC;
            6'b010010: arith_alu = ALU_ORCC;
            6'b010110: arith_alu = ALU_ORNCC;
            default:   arith_legal = 1'b0;
        endcase
    end

    // Instruction dispatch used when leaving DECODE. Every encoding that is
    // not explicitly recognised lands in ILLEGAL.
    always_comb begin
        dispatch_state = S_ILLEGAL;
        case (arc_control_unit_RegIR_OP)
            2'b10: begin
                if (arith_legal) begin
                    dispatch_state = arc_control_unit_RegIR_BIT13 ? S_ARITH_IMM : S_ARITH;
                end
            end
            2'b11: begin
                if (arc_control_unit_RegIR_OP3 == OP3_LD) begin
                    dispatch_state = arc_control_unit_RegIR_BIT13 ? S_ADDR_IMM : S_LD_A;
                end else if (arc_control_unit_RegIR_OP3 == OP3_ST) begin
                    dispatch_state = arc_control_unit_RegIR_BIT13 ? S_ADDR_IMM : S_ST_A;
                end
            end
            2'b00: begin
                if (arc_control_unit_RegIR_OP2 == 3'b100) begin
                    dispatch_state = S_SETHI;
                end else if (arc_control_unit_RegIR_OP2 == 3'b010 && branch_cond_legal) begin
                    dispatch_state = branch_taken ? S_BR_T : S_INC_PC;
                end
            end
            default: dispatch_state = S_ILLEGAL;
        endcase
    end

    // State register. Reset is synchronous and wins over every state,
    // including a pending memory wait.
    always_ff @(posedge arc_control_unit_CLOCK_50) begin
        if (!arc_control_unit_Reset_InLow) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Memory states wait indefinitely for the ack; the
    // end of every instruction either returns to FETCH or, in the
    // single-step build, parks in HALT until a step request arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH:     state_d = arc_control_unit_MemAck_InHigh ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = dispatch_state;
            S_ARITH_IMM: state_d = S_ARITH;
            S_ARITH:     state_d = S_INC_PC;
            S_ADDR_IMM:  state_d = (arc_control_unit_RegIR_OP3 == OP3_ST) ? S_ST_A : S_LD_A;
            S_LD_A:      state_d = S_LD_M;
            S_ST_A:      state_d = S_ST_M;
            S_LD_M:      state_d = arc_control_unit_MemAck_InHigh ? S_INC_PC : S_LD_M;
            S_ST_M:      state_d = arc_control_unit_MemAck_InHigh ? S_INC_PC : S_ST_M;
            S_SETHI:     state_d = S_INC_PC;
            S_BR_T:      state_d = S_BR_ADD;
`ifdef ARC_CU_SINGLESTEP_EN
            S_BR_ADD:    state_d = S_HALT;
            S_INC_PC:    state_d = S_HALT;
            S_HALT:      state_d = arc_control_unit_Step_InHigh ? S_FETCH : S_HALT;
`else
            S_BR_ADD:    state_d = S_FETCH;
            S_INC_PC:    state_d = S_FETCH;
            S_HALT:      state_d = S_FETCH;
`endif
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_RESET;
        endcase
    end

    // Output decode from the current state (and MemAck for the cycles that
    // complete a memory access). Everything starts idle and each state only
    // overrides what it actually uses.
    always_comb begin
        arc_control_unit_DecoderSelectionWrite_Out = DEST_NONE;
        arc_control_unit_MUXSelectionBUSA_Out      = MUX_ZERO;
        arc_control_unit_MUXSelectionBUSB_Out      = MUX_ZERO;
        arc_control_unit_ALUSelection_Out          = ALU_ANDCC;
        arc_control_unit_MemRead_OutHigh           = 1'b0;
        arc_control_unit_MemWrite_OutHigh          = 1'b0;
        arc_control_unit_Error_OutHigh             = 1'b0;
        case (state_q)
            S_FETCH: begin
                arc_control_unit_MemRead_OutHigh      = 1'b1;
                arc_control_unit_MUXSelectionBUSA_Out = MUX_PC;
                if (arc_control_unit_MemAck_InHigh) begin
                    arc_control_unit_DecoderSelectionWrite_Out = DEST_IR;
                end
            end
            S_ARITH_IMM, S_ADDR_IMM: begin
                arc_control_unit_MUXSelectionBUSA_Out      = MUX_IR;
                arc_control_unit_ALUSelection_Out          = ALU_SEXT13;
                arc_control_unit_DecoderSelectionWrite_Out = DEST_TEMP0;
            end
            S_ARITH: begin
                arc_control_unit_MUXSelectionBUSA_Out      = DATAWIDTH_MUX_SELECTION'(arc_control_unit_RegIR_RS1);
                arc_control_unit_MUXSelectionBUSB_Out      = operand_b_sel;
                arc_control_unit_ALUSelection_Out          = arith_alu;
                arc_control_unit_DecoderSelectionWrite_Out = DATAWIDTH_DECODER_SELECTION'(arc_control_unit_RegIR_RD);
            end
            S_LD_A, S_ST_A: begin
                arc_control_unit_MUXSelectionBUSA_Out      = DATAWIDTH_MUX_SELECTION'(arc_control_unit_RegIR_RS1);
                arc_control_unit_MUXSelectionBUSB_Out      = operand_b_sel;
                arc_control_unit_ALUSelection_Out          = ALU_ADD;
                arc_control_unit_DecoderSelectionWrite_Out = DEST_TEMP1;
            end
            S_LD_M: begin
                arc_control_unit_MemRead_OutHigh      = 1'b1;
                arc_control_unit_MUXSelectionBUSA_Out = MUX_TEMP1;
                if (arc_control_unit_MemAck_InHigh) begin
                    arc_control_unit_DecoderSelectionWrite_Out = DATAWIDTH_DECODER_SELECTION'(arc_control_unit_RegIR_RD);
                end
            end
            S_ST_M: begin
                arc_control_unit_MemWrite_OutHigh     = 1'b1;
                arc_control_unit_MUXSelectionBUSA_Out = MUX_TEMP1;
                arc_control_unit_MUXSelectionBUSB_Out = DATAWIDTH_MUX_SELECTION'(arc_control_unit_RegIR_RD);
            end
            S_SETHI: begin
                arc_control_unit_MUXSelectionBUSA_Out      = MUX_IR;
                arc_control_unit_ALUSelection_Out          = ALU_LSHIFT10;
                arc_control_unit_DecoderSelectionWrite_Out = DATAWIDTH_DECODER_SELECTION'(arc_control_unit_RegIR_RD);
            end
            S_BR_T: begin
                arc_control_unit_MUXSelectionBUSA_Out      = MUX_IR;
                arc_control_unit_ALUSelection_Out          = ALU_LSHIFT2;
                arc_control_unit_DecoderSelectionWrite_Out = DEST_TEMP0;
            end
            S_BR_ADD: begin
                arc_control_unit_MUXSelectionBUSA_Out      = MUX_PC;
                arc_control_unit_MUXSelectionBUSB_Out      = MUX_TEMP0;
                arc_control_unit_ALUSelection_Out          = ALU_ADD;
                arc_control_unit_DecoderSelectionWrite_Out = DEST_PC;
            end
            S_INC_PC: begin
                arc_control_unit_MUXSelectionBUSA_Out      = MUX_PC;
                arc_control_unit_ALUSelection_Out          = ALU_INCPC;
                arc_control_unit_DecoderSelectionWrite_Out = DEST_PC;
            end
            S_ILLEGAL: begin
                arc_control_unit_Error_OutHigh = 1'b1;
            end
            default: begin
                arc_control_unit_Error_OutHigh = 1'b0;
            end
        endcase
    end

    assign arc_control_unit_State_Out = state_q;

endmodule

// File: tb/tb_arc_control_unit.sv
// tb_arc_control_unit
// -------------------
// Directed bench for arc_control_unit. Each task walks one instruction (or
// one reset/error scenario) through the sequencer cycle by cycle, acting as
// the memory/datapath side, and compares the control outputs against
// hand-derived values. When ARC_CU_SINGLESTEP_EN is defined, Step is held
// high during the ordinary tests so each HALT lasts one cycle, and a
// dedicated single-step test runs at the end.

module tb_arc_control_unit;

    localparam logic [4:0] ST_RESET    = 5'd0;
    localparam logic [4:0] ST_FETCH    = 5'd1;
    localparam logic [4:0] ST_DECODE   = 5'd2;
    localparam logic [4:0] ST_ARITH_IMM = 5'd3;
    localparam logic [4:0] ST_ARITH    = 5'd4;
    localparam logic [4:0] ST_ADDR_IMM = 5'd5;
    localparam logic [4:0] ST_LD_A     = 5'd6;
    localparam logic [4:0] ST_ST_A     = 5'd7;
    localparam logic [4:0] ST_LD_M     = 5'd8;
    localparam logic [4:0] ST_ST_M     = 5'd9;
    localparam logic [4:0] ST_SETHI    = 5'd10;
    localparam logic [4:0] ST_BR_T     = 5'd11;
    localparam logic [4:0] ST_BR_ADD   = 5'd12;
    localparam logic [4:0] ST_INC_PC   = 5'd13;
    localparam logic [4:0] ST_ILLEGAL  = 5'd14;
    localparam logic [4:0] ST_HALT     = 5'd15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] op;
    logic [4:0] rd;
    logic [2:0] op2;
    logic [5:0] op3;
    logic [4:0] rs1;
    logic       bit13;
    logic [4:0] rs2;
    logic       n_l;
    logic       z_l;
    logic       v_l;
    logic       c_l;
    logic       ack;
`ifdef ARC_CU_SINGLESTEP_EN
    logic       step;
`endif
    logic [5:0] dec;
    logic [5:0] mux_a;
    logic [5:0] mux_b;
    logic [3:0] alu;
    logic       mem_rd;
    logic       mem_wr;
    logic       err;
    logic [4:0] state;

    int checks = 0;
    int fails  = 0;

    // Free-running 100 MHz-style clock for the unit under test.
    always #5 clk = ~clk;

    arc_control_unit dut (
        .arc_control_unit_CLOCK_50                  (clk),
        .arc_control_unit_Reset_InLow               (rst_n),
        .arc_control_unit_RegIR_OP                  (op),
        .arc_control_unit_RegIR_RD                  (rd),
        .arc_control_unit_RegIR_OP2                 (op2),
        .arc_control_unit_RegIR_OP3                 (op3),
        .arc_control_unit_RegIR_RS1                 (rs1),
        .arc_control_unit_RegIR_BIT13               (bit13),
        .arc_control_unit_RegIR_RS2                 (rs2),
        .arc_control_unit_Negative_InLow            (n_l),
        .arc_control_unit_Zero_InLow                (z_l),
        .arc_control_unit_Overflow_InLow            (v_l),
        .arc_control_unit_Carry_InLow               (c_l),
        .arc_control_unit_MemAck_InHigh             (ack),
`ifdef ARC_CU_SINGLESTEP_EN
        .arc_control_unit_Step_InHigh               (step),
`endif
        .arc_control_unit_DecoderSelectionWrite_Out (dec),
        .arc_control_unit_MUXSelectionBUSA_Out      (mux_a),
        .arc_control_unit_MUXSelectionBUSB_Out      (mux_b),
        .arc_control_unit_ALUSelection_Out          (alu),
        .arc_control_unit_MemRead_OutHigh           (mem_rd),
        .arc_control_unit_MemWrite_OutHigh          (mem_wr),
        .arc_control_unit_Error_OutHigh             (err),
        .arc_control_unit_State_Out                 (state)
    );

    // Advance one clock and land just after the edge, where outputs are stable.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Split a 32-bit instruction word into the IR fields the datapath provides.
    task automatic set_ir(input logic [31:0] ir);
        op    = ir[31:30];
        rd    = ir[29:25];
        op2   = ir[24:22];
        op3   = ir[24:19];
        rs1   = ir[18:14];
        bit13 = ir[13];
        rs2   = ir[4:0];
    endtask

    // From FETCH: acknowledge the instruction read and move into DECODE.
    task automatic fetch_and_decode(input logic [31:0] ir);
        set_ir(ir);
        ack = 1'b1;
        #1;
        tick;
        ack = 1'b0;
        #1;
    endtask

    // From the last state of an instruction, step until FETCH is reached.
    task automatic tick_to_fetch;
        tick;
`ifdef ARC_CU_SINGLESTEP_EN
        tick;
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ack   = 1'b0;
        repeat (3) tick;
        checks++;
        if (state !== ST_RESET || dec !== 6'd63 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_idle: state=%0d dec=%0d rd=%0b wr=%0b err=%0b, want state=0 dec=63 rd=0 wr=0 err=0",
                     state, dec, mem_rd, mem_wr, err);
        end
        checks++;
        if (mux_a !== 6'd0 || mux_b !== 6'd0 || alu !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_mux_alu: muxA=%0d muxB=%0d alu=%0d, want 0 0 0", mux_a, mux_b, alu);
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if (state !== ST_FETCH || mem_rd !== 1'b1 || mux_a !== 6'd32 || dec !== 6'd63) begin
            fails++;
            $display("[TB] FAIL reset_release_fetch: state=%0d rd=%0b muxA=%0d dec=%0d, want state=1 rd=1 muxA=32 dec=63",
                     state, mem_rd, mux_a, dec);
        end
    endtask

    // addcc r1, r1, r2
    task automatic test_arith_reg;
        set_ir(32'h82804002);
        ack = 1'b1;
        #1;
        checks++;
        if (dec !== 6'd33 || mem_rd !== 1'b1 || mux_a !== 6'd32) begin
            fails++;
            $display("[TB] FAIL fetch_ack: dec=%0d rd=%0b muxA=%0d, want dec=33 rd=1 muxA=32", dec, mem_rd, mux_a);
        end
        tick;
        ack = 1'b0;
        #1;
        checks++;
        if (state !== ST_DECODE || dec !== 6'd63 || mem_rd !== 1'b0 || mux_a !== 6'd0 || alu !== 4'd0) begin
            fails++;
            $display("[TB] FAIL decode_idle: state=%0d dec=%0d rd=%0b muxA=%0d alu=%0d, want 2 63 0 0 0",
                     state, dec, mem_rd, mux_a, alu);
        end
        tick;
        checks++;
        if (state !== ST_ARITH || mux_a !== 6'd1 || mux_b !== 6'd2 || alu !== 4'd3 || dec !== 6'd1) begin
            fails++;
            $display("[TB] FAIL arith_reg: state=%0d muxA=%0d muxB=%0d alu=%0d dec=%0d, want 4 1 2 3 1",
                     state, mux_a, mux_b, alu, dec);
        end
        tick;
        checks++;
        if (state !== ST_INC_PC || mux_a !== 6'd32 || alu !== 4'd14 || dec !== 6'd32) begin
            fails++;
            $display("[TB] FAIL inc_pc: state=%0d muxA=%0d alu=%0d dec=%0d, want 13 32 14 32", state, mux_a, alu, dec);
        end
        tick_to_fetch;
        checks++;
        if (state !== ST_FETCH) begin
            fails++;
            $display("[TB] FAIL arith_back_to_fetch: state=%0d, want 1", state);
        end
    endtask

    // orcc r2, 5, r3
    task automatic test_arith_imm;
        fetch_and_decode(32'h8690A005);
        tick;
        checks++;
        if (state !== ST_ARITH_IMM || mux_a !== 6'd33 || alu !== 4'd12 || dec !== 6'd34) begin
            fails++;
            $display("[TB] FAIL arith_imm_sext: state=%0d muxA=%0d alu=%0d dec=%0d, want 3 33 12 34", state, mux_a, alu, dec);
        end
        tick;
        checks++;
        if (state !== ST_ARITH || mux_a !== 6'd2 || mux_b !== 6'd34 || alu !== 4'd1 || dec !== 6'd3) begin
            fails++;
            $display("[TB] FAIL arith_imm_op: state=%0d muxA=%0d muxB=%0d alu=%0d dec=%0d, want 4 2 34 1 3",
                     state, mux_a, mux_b, alu, dec);
        end
        tick;
        checks++;
        if (state !== ST_INC_PC) begin
            fails++;
            $display("[TB] FAIL arith_imm_inc_pc: state=%0d, want 13", state);
        end
        tick_to_fetch;
    endtask

    // ld [r1+16], r1 with the memory ack arriving on the fifth LD_M cycle
    task automatic test_load_wait;
        int rd_cycles;
        rd_cycles = 0;
        fetch_and_decode(32'hC2006010);
        tick;
        checks++;
        if (state !== ST_ADDR_IMM || mux_a !== 6'd33 || alu !== 4'd12 || dec !== 6'd34) begin
            fails++;
            $display("[TB] FAIL ld_addr_imm: state=%0d muxA=%0d alu=%0d dec=%0d, want 5 33 12 34", state, mux_a, alu, dec);
        end
        tick;
        checks++;
        if (state !== ST_LD_A || mux_a !== 6'd1 || mux_b !== 6'd34 || alu !== 4'd8 || dec !== 6'd35) begin
            fails++;
            $display("[TB] FAIL ld_addr: state=%0d muxA=%0d muxB=%0d alu=%0d dec=%0d, want 6 1 34 8 35",
                     state, mux_a, mux_b, alu, dec);
        end
        tick;
        for (int i = 0; i < 4; i++) begin
            if (mem_rd === 1'b1) rd_cycles++;
            checks++;
            if (state !== ST_LD_M || mux_a !== 6'd35 || dec !== 6'd63) begin
                fails++;
                $display("[TB] FAIL ld_wait_%0d: state=%0d muxA=%0d dec=%0d, want 8 35 63", i, state, mux_a, dec);
            end
            tick;
        end
        ack = 1'b1;
        #1;
        if (mem_rd === 1'b1) rd_cycles++;
        checks++;
        if (dec !== 6'd1 || mux_a !== 6'd35) begin
            fails++;
            $display("[TB] FAIL ld_ack_dest: dec=%0d muxA=%0d, want dec=1 muxA=35", dec, mux_a);
        end
        tick;
        ack = 1'b0;
        #1;
        checks++;
        if (state !== ST_INC_PC || mem_rd !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ld_after_ack: state=%0d rd=%0b, want 13 0", state, mem_rd);
        end
        checks++;
        if (rd_cycles != 5) begin
            fails++;
            $display("[TB] FAIL ld_memread_cycles: got %0d cycles, want 5", rd_cycles);
        end
        tick_to_fetch;
    endtask

    // st r5, [r1+r2] with a one-cycle wait
    task automatic test_store;
        fetch_and_decode(32'hCA204002);
        tick;
        checks++;
        if (state !== ST_ST_A || mux_a !== 6'd1 || mux_b !== 6'd2 || alu !== 4'd8 || dec !== 6'd35) begin
            fails++;
            $display("[TB] FAIL st_addr: state=%0d muxA=%0d muxB=%0d alu=%0d dec=%0d, want 7 1 2 8 35",
                     state, mux_a, mux_b, alu, dec);
        end
        tick;
        checks++;
        if (state !== ST_ST_M || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mux_a !== 6'd35 || mux_b !== 6'd5 || dec !== 6'd63) begin
            fails++;
            $display("[TB] FAIL st_mem: state=%0d wr=%0b rd=%0b muxA=%0d muxB=%0d dec=%0d, want 9 1 0 35 5 63",
                     state, mem_wr, mem_rd, mux_a, mux_b, dec);
        end
        tick;
        ack = 1'b1;
        #1;
        tick;
        ack = 1'b0;
        #1;
        checks++;
        if (state !== ST_INC_PC || mem_wr !== 1'b0) begin
            fails++;
            $display("[TB] FAIL st_after_ack: state=%0d wr=%0b, want 13 0", state, mem_wr);
        end
        tick_to_fetch;
    endtask

    // sethi 0x1234, r4
    task automatic test_sethi;
        fetch_and_decode(32'h09001234);
        tick;
        checks++;
        if (state !== ST_SETHI || mux_a !== 6'd33 || alu !== 4'd10 || dec !== 6'd4) begin
            fails++;
            $display("[TB] FAIL sethi: state=%0d muxA=%0d alu=%0d dec=%0d, want 10 33 10 4", state, mux_a, alu, dec);
        end
        tick;
        checks++;
        if (state !== ST_INC_PC) begin
            fails++;
            $display("[TB] FAIL sethi_inc_pc: state=%0d, want 13", state);
        end
        tick_to_fetch;
    endtask

    // be taken, be not taken, ba taken with Z clear
    task automatic test_branch;
        z_l = 1'b0;
        fetch_and_decode(32'h02800003);
        tick;
        checks++;
        if (state !== ST_BR_T || mux_a !== 6'd33 || alu !== 4'd9 || dec !== 6'd34) begin
            fails++;
            $display("[TB] FAIL be_taken_disp: state=%0d muxA=%0d alu=%0d dec=%0d, want 11 33 9 34", state, mux_a, alu, dec);
        end
        tick;
        checks++;
        if (state !== ST_BR_ADD || mux_a !== 6'd32 || mux_b !== 6'd34 || alu !== 4'd8 || dec !== 6'd32) begin
            fails++;
            $display("[TB] FAIL be_taken_add: state=%0d muxA=%0d muxB=%0d alu=%0d dec=%0d, want 12 32 34 8 32",
                     state, mux_a, mux_b, alu, dec);
        end
        tick_to_fetch;
        checks++;
        if (state !== ST_FETCH || mem_rd !== 1'b1) begin
            fails++;
            $display("[TB] FAIL be_taken_no_inc_pc: state=%0d rd=%0b, want 1 1", state, mem_rd);
        end
        z_l = 1'b1;
        fetch_and_decode(32'h02800003);
        tick;
        checks++;
        if (state !== ST_INC_PC || alu !== 4'd14) begin
            fails++;
            $display("[TB] FAIL be_not_taken: state=%0d alu=%0d, want 13 14", state, alu);
        end
        tick_to_fetch;
        fetch_and_decode(32'h10800003);
        tick;
        checks++;
        if (state !== ST_BR_T) begin
            fails++;
            $display("[TB] FAIL ba_always: state=%0d, want 11", state);
        end
        tick;
        tick_to_fetch;
    endtask

    // ld [r0+r0], r0 is a legal load
    task automatic test_ld_r0;
        fetch_and_decode(32'hC0000000);
        tick;
        checks++;
        if (state !== ST_LD_A || err !== 1'b0 || mux_a !== 6'd0 || mux_b !== 6'd0 || dec !== 6'd35) begin
            fails++;
            $display("[TB] FAIL ld_r0_addr: state=%0d err=%0b muxA=%0d muxB=%0d dec=%0d, want 6 0 0 0 35",
                     state, err, mux_a, mux_b, dec);
        end
        tick;
        ack = 1'b1;
        #1;
        checks++;
        if (state !== ST_LD_M || dec !== 6'd0 || mem_rd !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ld_r0_ack: state=%0d dec=%0d rd=%0b, want 8 0 1", state, dec, mem_rd);
        end
        tick;
        ack = 1'b0;
        #1;
        tick_to_fetch;
    endtask

    // Reset held low for three cycles while a load is waiting on memory
    task automatic test_reset_mid_wait;
        fetch_and_decode(32'hC0000000);
        tick;
        tick;
        checks++;
        if (state !== ST_LD_M || mem_rd !== 1'b1) begin
            fails++;
            $display("[TB] FAIL wait_before_reset: state=%0d rd=%0b, want 8 1", state, mem_rd);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (state !== ST_RESET || dec !== 6'd63 || mem_rd !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_in_wait_%0d: state=%0d dec=%0d rd=%0b, want 0 63 0", i, state, dec, mem_rd);
            end
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if (state !== ST_FETCH || mem_rd !== 1'b1 || mux_a !== 6'd32) begin
            fails++;
            $display("[TB] FAIL reset_wait_release: state=%0d rd=%0b muxA=%0d, want 1 1 32", state, mem_rd, mux_a);
        end
    endtask

    // Unsupported op3 (restore-style encoding) and an unsupported branch cond
    task automatic test_illegal;
        fetch_and_decode(32'h81E80000);
        tick;
        checks++;
        if (state !== ST_ILLEGAL || err !== 1'b1 || dec !== 6'd63 || mem_rd !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_op3: state=%0d err=%0b dec=%0d rd=%0b, want 14 1 63 0", state, err, dec, mem_rd);
        end
        set_ir(32'h82804002);
        ack = 1'b1;
        repeat (3) tick;
        ack = 1'b0;
        #1;
        checks++;
        if (state !== ST_ILLEGAL || err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL illegal_sticky: state=%0d err=%0b, want 14 1", state, err);
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if (state !== ST_RESET || err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_cleared: state=%0d err=%0b, want 0 0", state, err);
        end
        rst_n = 1'b1;
        tick;
        fetch_and_decode(32'h04800003);
        tick;
        checks++;
        if (state !== ST_ILLEGAL || err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL illegal_cond: state=%0d err=%0b, want 14 1", state, err);
        end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

`ifdef ARC_CU_SINGLESTEP_EN
    // One step pulse lets exactly one instruction through, then HALT again
    task automatic test_single_step;
        step = 1'b0;
        fetch_and_decode(32'h09001234);
        tick;
        tick;
        tick;
        repeat (3) tick;
        checks++;
        if (state !== ST_HALT || mem_rd !== 1'b0) begin
            fails++;
            $display("[TB] FAIL halt_wait: state=%0d rd=%0b, want 15 0", state, mem_rd);
        end
        step = 1'b1;
        #1;
        tick;
        step = 1'b0;
        #1;
        checks++;
        if (state !== ST_FETCH) begin
            fails++;
            $display("[TB] FAIL step_to_fetch: state=%0d, want 1", state);
        end
        fetch_and_decode(32'h09001234);
        tick;
        tick;
        tick;
        tick;
        checks++;
        if (state !== ST_HALT) begin
            fails++;
            $display("[TB] FAIL step_once: state=%0d, want 15", state);
        end
    endtask
`endif

    // Main sequence: initialise inputs, then run each scenario in turn.
    initial begin
        rst_n = 1'b0;
        ack   = 1'b0;
        n_l   = 1'b1;
        z_l   = 1'b1;
        v_l   = 1'b1;
        c_l   = 1'b1;
`ifdef ARC_CU_SINGLESTEP_EN
        step  = 1'b1;
`endif
        set_ir(32'h00000000);
        test_reset;
        test_arith_reg;
        test_arith_imm;
        test_load_wait;
        test_store;
        test_sethi;
        test_branch;
        test_ld_r0;
        test_reset_mid_wait;
        test_illegal;
`ifdef ARC_CU_SINGLESTEP_EN
        test_single_step;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
